// File: rtl/bcd_sched_pkg.sv
// Shared constants, state encoding and sign/magnitude helper for the BCD channel scheduler.
package bcd_sched_pkg;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned IN_W    = 16;
  localparam int unsigned DEC_W   = 20;
  localparam int unsigned BCD_LAT = 3;
  localparam int unsigned CH_W    = $clog2(NUM_CH);
  // Tag layout: {valid, ch_idx, sign}
  localparam int unsigned TAG_W   = CH_W + 2;
  localparam int unsigned DRAIN_W = $clog2(BCD_LAT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // -32768 maps to magnitude 16'h8000, which fits as unsigned, so no saturation.
  function automatic logic [IN_W:0] to_sign_mag(input logic [IN_W-1:0] s);
    logic [IN_W-1:0] mag;
    mag = s[IN_W-1] ? (~s + 1'b1) : s;
    return {s[IN_W-1], mag};
  endfunction

endpackage

// File: rtl/bcd_tag_pipe.sv
// Fixed-depth delay line that carries per-issue tags alongside the shared converter.
module bcd_tag_pipe #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] tag,
  output logic [Width-1:0] tag_dly
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_dly = stage_q[Depth-1];

endmodule

// File: rtl/bcd_channel_scheduler.sv
// Issues one snapshotted channel per cycle to a shared pipelined hex-to-BCD converter and
// collects the tagged results into a per-channel {sign, BCD} bank.
module bcd_channel_scheduler
  import bcd_sched_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ad_valid,
  input  logic [NUM_CH*IN_W-1:0]       ad_data,
  output logic [IN_W:0]                bcd_hex,
  input  logic [DEC_W-1:0]             bcd_dec,
  output logic [NUM_CH*(DEC_W+1)-1:0]  dec_bank,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_idx_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [IN_W-1:0]    snap_q [NUM_CH];
  logic [DEC_W:0]     bank_q [NUM_CH];
  logic               overrun_q;
  logic [TAG_W-1:0]   tag, tag_dly;
  logic               issuing;

  assign issuing = (state_q == StIssue);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ad_valid) state_d = StIssue;
      StIssue: if (ch_idx_q == CH_W'(NUM_CH - 1)) state_d = StDrain;
      StDrain: if (drain_cnt_q == DRAIN_W'(BCD_LAT - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ch_idx_q    <= '0;
      drain_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= issuing ? ch_idx_q + 1'b1 : '0;
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
      // A rejected strobe beats a same-cycle clear.
      if (ad_valid && state_q != StIdle) overrun_q <= 1'b1;
      else if (overrun_clr)              overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StIdle && ad_valid) begin
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= ad_data[i*IN_W +: IN_W];
    end
  end

  always_comb begin
    bcd_hex = '0;
    if (issuing) bcd_hex = to_sign_mag(snap_q[ch_idx_q]);
  end

  assign tag = {issuing, ch_idx_q, bcd_hex[IN_W]};

  bcd_tag_pipe #(
    .Depth (BCD_LAT),
    .Width (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag     (tag),
    .tag_dly (tag_dly)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
    end else if (tag_dly[TAG_W-1]) begin
      bank_q[tag_dly[CH_W:1]] <= {tag_dly[0], bcd_dec};
    end
  end

  always_comb begin
    dec_bank = '0;
    for (int i = 0; i < NUM_CH; i++) dec_bank[i*(DEC_W+1) +: DEC_W+1] = bank_q[i];
  end

  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_bcd_channel_scheduler.sv
// Directed bench: scheduler plus a behavioural 3-cycle hex-to-BCD converter.
module tb_bcd_channel_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ad_valid = 1'b0;
  logic [127:0] ad_data = '0;
  logic [16:0]  bcd_hex;
  logic [19:0]  bcd_dec;
  logic [167:0] dec_bank;
  logic         busy, frame_done, overrun;
  logic         overrun_clr = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [19:0] conv_q [3] = '{default: '0};

  logic [127:0] d1, d2, d3, djunk;
  logic [20:0]  exp1 [8], exp2 [8], exp3 [8], zero [8];

  always #5 clk = ~clk;

  bcd_channel_scheduler u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ad_valid    (ad_valid),
    .ad_data     (ad_data),
    .bcd_hex     (bcd_hex),
    .bcd_dec     (bcd_dec),
    .dec_bank    (dec_bank),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  function automatic logic [19:0] to_bcd(input logic [15:0] v);
    int unsigned x;
    logic [19:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    conv_q[0] <= to_bcd(bcd_hex[15:0]);
    conv_q[1] <= conv_q[0];
    conv_q[2] <= conv_q[1];
  end
  assign bcd_dec = conv_q[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string p, input logic [20:0] want [8]);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s bank ch%0d", p, i), 64'(dec_bank[i*21 +: 21]), 64'(want[i]));
  endtask

  // Leaves the bench in cycle 1 of the new frame.
  task automatic start_frame(input logic [127:0] d);
    ad_data  = d;
    ad_valid = 1'b1;
    tick();
    ad_valid = 1'b0;
  endtask

  initial begin
    d1 = {16'h00FF, 16'h8000, 16'h7FFF, 16'hCFC7, 16'h3039, 16'hFFFF, 16'h0001, 16'h0000};
    exp1 = '{21'h000000, 21'h000001, 21'h100001, 21'h012345,
             21'h112345, 21'h032767, 21'h132768, 21'h000255};
    for (int i = 0; i < 8; i++) begin
      d2[i*16 +: 16] = 16'(i + 10);
      exp2[i]        = 21'h000010 + 21'(i);
      d3[i*16 +: 16] = (i % 2 == 0) ? 16'd100 : 16'hD8F1;
      exp3[i]        = (i % 2 == 0) ? 21'h000100 : 21'h109999;
      djunk[i*16 +: 16] = 16'h1111;
      zero[i]        = '0;
    end

    // Reset state
    tick();
    tick();
    check("rst busy", 64'(busy), 64'd0);
    check("rst frame_done", 64'(frame_done), 64'd0);
    check("rst overrun", 64'(overrun), 64'd0);
    check("rst bcd_hex", 64'(bcd_hex), 64'd0);
    check_bank("rst", zero);
    rst_n = 1'b1;
    tick();

    // Frame 1: conversion values and latency
    start_frame(d1);
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("f1 busy c%0d", c), 64'(busy), 64'(c <= 12));
      check($sformatf("f1 done c%0d", c), 64'(frame_done), 64'(c == 12));
      if (c == 3) check("f1 hex ch2", 64'(bcd_hex), 64'h10001);
      if (c == 7) check("f1 hex ch6", 64'(bcd_hex), 64'h18000);
      if (c == 7) check("f1 ch3 old", 64'(dec_bank[3*21 +: 21]), 64'd0);
      if (c == 8) check("f1 ch3 new", 64'(dec_bank[3*21 +: 21]), 64'(exp1[3]));
      if (c == 13) check("f1 hex idle", 64'(bcd_hex), 64'd0);
      if (c < 13) tick();
    end
    check_bank("f1", exp1);
    check("f1 overrun", 64'(overrun), 64'd0);

    // Frame 2: rejected strobe, then clear and reject in the same cycle
    start_frame(d2);
    for (int c = 1; c <= 13; c++) begin
      if (c == 6) check("f2 overrun set", 64'(overrun), 64'd1);
      if (c == 8) check("f2 clr vs set", 64'(overrun), 64'd1);
      ad_valid    = (c == 5 || c == 7);
      ad_data     = (c == 5 || c == 7) ? djunk : d2;
      overrun_clr = (c == 7);
      check($sformatf("f2 done c%0d", c), 64'(frame_done), 64'(c == 12));
      if (c < 13) tick();
    end
    ad_valid    = 1'b0;
    overrun_clr = 1'b0;
    check_bank("f2", exp2);
    check("f2 overrun held", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("f2 overrun cleared", 64'(overrun), 64'd0);

    // Back-to-back frames
    start_frame(d1);
    for (int c = 1; c <= 26; c++) begin
      if (c == 13) begin
        ad_data  = d3;
        ad_valid = 1'b1;
      end else begin
        ad_valid = 1'b0;
      end
      check($sformatf("b2b done c%0d", c), 64'(frame_done), 64'(c == 12 || c == 25));
      check($sformatf("b2b busy c%0d", c), 64'(busy), 64'(c != 13 && c <= 25));
      if (c == 13) check_bank("b2b first", exp1);
      if (c < 26) tick();
    end
    ad_valid = 1'b0;
    check("b2b overrun", 64'(overrun), 64'd0);
    check_bank("b2b second", exp3);

    // Reset mid-frame
    start_frame(d2);
    for (int c = 1; c < 6; c++) tick();
    check("mid ch0 written", 64'(dec_bank[20:0]), 64'(exp2[0]));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_bank("mid rst", zero);
    check("mid busy", 64'(busy), 64'd0);
    for (int c = 8; c <= 16; c++) begin
      check($sformatf("mid done c%0d", c), 64'(frame_done), 64'd0);
      tick();
    end
    check_bank("mid still clear", zero);
    start_frame(d3);
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("post done c%0d", c), 64'(frame_done), 64'(c == 12));
      if (c < 13) tick();
    end
    check_bank("post", exp3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
